// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - conditional-execution and flag-commit unit (IDLE/EVAL/COMMIT)
module cond_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       Valid,
   output logic       Ready,
   input  logic [3:0] Cond,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   input  logic [3:0] ALUFlags,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags,
   output logic       Done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EVAL   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   logic [1:0] state;
   logic [3:0] cond_q;
   logic [1:0] flagw_q;
   logic       pcs_q;
   logic       regw_q;
   logic       memw_q;
   logic       nowrite_q;
   logic [3:0] alu_q;
   logic       pass;

   // Flags register bit aliases: {N,Z,C,V}
   logic n_f, z_f, c_f, v_f;
   assign n_f = Flags[3];
   assign z_f = Flags[2];
   assign c_f = Flags[1];
   assign v_f = Flags[0];

   assign Ready = (state == IDLE);

   // Condition test against the pre-instruction Flags register
   always_comb begin
      pass = 1'b0;
      case (cond_q)
         4'b0000: pass = z_f;
         4'b0001: pass = ~z_f;
         4'b0010: pass = c_f;
         4'b0011: pass = ~c_f;
         4'b0100: pass = n_f;
         4'b0101: pass = ~n_f;
         4'b0110: pass = v_f;
         4'b0111: pass = ~v_f;
         4'b1000: pass = c_f & ~z_f;
         4'b1001: pass = ~c_f | z_f;
         4'b1010: pass = (n_f == v_f);
         4'b1011: pass = (n_f != v_f);
         4'b1100: pass = ~z_f & (n_f == v_f);
         4'b1101: pass = z_f | (n_f != v_f);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   // Sequencer: capture in IDLE, evaluate in EVAL, strobe and update flags out of COMMIT
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         Flags     <= 4'b0000;
         CondEx    <= 1'b0;
         PCSrc     <= 1'b0;
         RegWrite  <= 1'b0;
         MemWrite  <= 1'b0;
         Done      <= 1'b0;
         cond_q    <= 4'b0000;
         flagw_q   <= 2'b00;
         pcs_q     <= 1'b0;
         regw_q    <= 1'b0;
         memw_q    <= 1'b0;
         nowrite_q <= 1'b0;
         alu_q     <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               if (Valid) begin
                  cond_q    <= Cond;
                  flagw_q   <= FlagW;
                  pcs_q     <= PCS;
                  regw_q    <= RegW;
                  memw_q    <= MemW;
                  nowrite_q <= NoWrite;
                  state     <= EVAL;
               end
            end
            EVAL: begin
               CondEx   <= pass;
               alu_q    <= ALUFlags;
               PCSrc    <= pcs_q & pass;
               RegWrite <= regw_q & ~nowrite_q & pass;
               MemWrite <= memw_q & pass;
               Done     <= 1'b1;
               state    <= COMMIT;
            end
            COMMIT: begin
               PCSrc    <= 1'b0;
               RegWrite <= 1'b0;
               MemWrite <= 1'b0;
               Done     <= 1'b0;
               if (flagw_q[1] & CondEx) Flags[3:2] <= alu_q[3:2];
               if (flagw_q[0] & CondEx) Flags[1:0] <= alu_q[1:0];
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit
module tb_cond_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       Valid;
   logic       Ready;
   logic [3:0] Cond;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic [3:0] ALUFlags;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;
   logic       Done;

   int total = 0;
   int bad   = 0;

   // observation/expectation layout:
   // [13] eval quiet, [12:10] Done latency, [9:6] {CondEx,PCSrc,RegWrite,MemWrite},
   // [5:2] Flags after commit, [1] Ready after commit, [0] Done after commit
   logic [13:0] sb[$];
   logic [3:0]  model_flags;

   cond_unit dut (
      .clk(clk), .rst(rst), .Valid(Valid), .Ready(Ready), .Cond(Cond), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .ALUFlags(ALUFlags),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .Done(Done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cf;
         4'h3: return !cf;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cf && !z;
         4'h9: return !cf || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic run_instr(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                            input logic regw, input logic memw, input logic nowr,
                            input logic [3:0] alu, input logic glitch, output logic [13:0] obs);
      logic       cx;
      logic [3:0] nf;
      int         lat;
      logic       quiet;
      cx = cond_ok(c, model_flags);
      nf = model_flags;
      if (cx && fw[1]) nf[3:2] = alu[3:2];
      if (cx && fw[0]) nf[1:0] = alu[1:0];
      sb.push_back({1'b1, 3'd2, cx, pcs & cx, regw & ~nowr & cx, memw & cx, nf, 1'b1, 1'b0});
      model_flags = nf;
      Cond = c; FlagW = fw; PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr;
      ALUFlags = 4'($urandom);
      Valid = 1'b1;
      lat = 0;
      quiet = 1'b0;
      while (lat < 6) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            quiet = !Done && !PCSrc && !RegWrite && !MemWrite && !Ready;
            ALUFlags = alu;
            Valid = glitch;
            Cond = 4'($urandom);
            FlagW = 2'b11; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
         end
         if (Done) break;
      end
      obs[13]    = quiet;
      obs[12:10] = lat[2:0];
      obs[9:6]   = {CondEx, PCSrc, RegWrite, MemWrite};
      Valid = 1'b0;
      ALUFlags = 4'($urandom);
      @(negedge clk);
      obs[5:2] = Flags;
      obs[1]   = Ready;
      obs[0]   = Done;
   endtask

   task automatic test_reset;
      rst = 1'b1; Valid = 1'b1; Cond = 4'hE; FlagW = 2'b11; PCS = 1'b1; RegW = 1'b1;
      MemW = 1'b1; NoWrite = 1'b0; ALUFlags = 4'hF;
      repeat (3) @(negedge clk);
      rst = 1'b0; Valid = 1'b0;
      model_flags = 4'b0000;
      total++;
      if (Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", Ready); end
      total++;
      if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", Flags); end
      total++;
      if ({CondEx, PCSrc, RegWrite, MemWrite, Done} !== 5'b00000) begin
         bad++; $display("FAIL reset_outputs: got %b want 00000", {CondEx, PCSrc, RegWrite, MemWrite, Done});
      end
   endtask

   task automatic test_al_regwrite;
      logic [13:0] o, e;
      run_instr(4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL al_regwrite: got %b want %b", o, e); end
      total++;
      if (o[5:2] !== 4'b0100) begin bad++; $display("FAIL al_flags: got %b want 0100", o[5:2]); end
   endtask

   task automatic test_eq_ne;
      logic [13:0] o, e;
      run_instr(4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL eq_branch: got %b want %b", o, e); end
      total++;
      if (o[8] !== 1'b1) begin bad++; $display("FAIL eq_pcsrc: got %b want 1", o[8]); end
      run_instr(4'h1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL ne_branch: got %b want %b", o, e); end
      total++;
      if (o[8] !== 1'b0 || o[12:10] !== 3'd2) begin
         bad++; $display("FAIL ne_pcsrc_done: got pcsrc=%b lat=%0d want pcsrc=0 lat=2", o[8], o[12:10]);
      end
   endtask

   task automatic test_partial_flags;
      logic [13:0] o, e;
      run_instr(4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL clear_flags: got %b want %b", o, e); end
      run_instr(4'hE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o[5:2] !== 4'b1000 || o !== e) begin
         bad++; $display("FAIL partial_flags: got %b want %b", o, e);
      end
   endtask

   task automatic test_cmp;
      logic [13:0] o, e;
      run_instr(4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL cmp: got %b want %b", o, e); end
      total++;
      if (o[7] !== 1'b0 || o[5:2] !== 4'b0110) begin
         bad++; $display("FAIL cmp_nowrite: got regwrite=%b flags=%b want 0 0110", o[7], o[5:2]);
      end
   endtask

   task automatic test_lt_reserved;
      logic [13:0] o, e;
      run_instr(4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL set_n: got %b want %b", o, e); end
      run_instr(4'hB, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, o);
      e = sb.pop_front();
      total++;
      if (o[9] !== 1'b1 || o !== e) begin bad++; $display("FAIL lt_condex: got %b want %b", o, e); end
      run_instr(4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b1, o);
      e = sb.pop_front();
      total++;
      if (o[9:6] !== 4'b0000 || o !== e) begin bad++; $display("FAIL reserved_nv: got %b want %b", o, e); end
      @(negedge clk);
      total++;
      if (Ready !== 1'b1 || Done !== 1'b0) begin
         bad++; $display("FAIL eval_valid_ignored: got ready=%b done=%b want 1 0", Ready, Done);
      end
   endtask

   task automatic test_back_to_back;
      logic [13:0] o, e;
      for (int i = 0; i < 24; i++) begin
         run_instr(4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 4'($urandom), 1'($urandom), o);
         e = sb.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL back_to_back[%0d]: got %b want %b", i, o, e); end
      end
   endtask

   task automatic test_reset_commit;
      int n;
      Cond = 4'hE; FlagW = 2'b11; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
      Valid = 1'b1;
      @(negedge clk);
      Valid = 1'b0; ALUFlags = 4'b1111;
      n = 0;
      while (!Done && n < 5) begin @(negedge clk); n++; end
      total++;
      if (Done !== 1'b1 || n !== 1) begin bad++; $display("FAIL rc_reach_commit: got done=%b wait=%0d want 1 1", Done, n); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_flags = 4'b0000;
      total++;
      if (Flags !== 4'b0000 || Done !== 1'b0 || {PCSrc, RegWrite, MemWrite} !== 3'b000) begin
         bad++; $display("FAIL rc_abandon: got flags=%b done=%b strobes=%b want 0000 0 000",
                         Flags, Done, {PCSrc, RegWrite, MemWrite});
      end
      @(negedge clk);
      total++;
      if (Ready !== 1'b1 || Flags !== 4'b0000 || Done !== 1'b0) begin
         bad++; $display("FAIL rc_ready: got ready=%b flags=%b done=%b want 1 0000 0", Ready, Flags, Done);
      end
   endtask

   initial begin
      test_reset();
      test_al_regwrite();
      test_eq_ne();
      test_partial_flags();
      test_cmp();
      test_lt_reserved();
      test_back_to_back();
      test_reset_commit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
